// File: rtl/assoc_way_select_pipe.sv
// assoc_way_select_pipe
// Pipelined priority way-select stage for set-associative arrays (caches, TLBs).
// Resolves a hit vector to one way (the highest set bit wins) and registers the
// selected element behind a valid/ready handshake with 1-cycle latency.
// It also keeps saturating hit/miss statistics.
//
// Ports:
//   clk_in, reset_in        clock; synchronous active-high reset
//   way_packed_in           all ways packed; way g at [(g+1)*W-1 : g*W]
//   sel_in                  hit vector, one bit per way
//   valid_in / ready_out    upstream handshake (ready_out is combinational)
//   valid_out / ready_in    downstream handshake
//   way_packed_out          selected element
//   way_index_out           index of the selected way
//   hit_out, multi_hit_out  any hit / two or more hits
//   clear_stats_in          zero the statistic counters (wins over an increment)
//   hit_count_out           saturating count of accepted hits
//   miss_count_out          saturating count of accepted misses
//
// Optional feature, macro ASSOC_MULTI_HIT_TRAP_EN:
//   adds the sticky output multi_hit_err_out. A multi-hit accept forces
//   way_packed_out and hit_out to zero.
module assoc_way_select_pipe #(
  parameter int unsigned NUMBER_WAYS                 = 16,
  parameter int unsigned SINGLE_ELEMENT_SIZE_IN_BITS = 32,
  parameter int unsigned WAY_INDEX_WIDTH             = 4,
  parameter int unsigned COUNTER_WIDTH               = 16
) (
  input  logic                                               clk_in,
  input  logic                                               reset_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS*NUMBER_WAYS-1:0] way_packed_in,
  input  logic [NUMBER_WAYS-1:0]                             sel_in,
  input  logic                                               valid_in,
  output logic                                               ready_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             way_packed_out,
  output logic [WAY_INDEX_WIDTH-1:0]                         way_index_out,
  output logic                                               hit_out,
  output logic                                               multi_hit_out,
  output logic                                               valid_out,
  input  logic                                               ready_in,
  input  logic                                               clear_stats_in,
`ifdef ASSOC_MULTI_HIT_TRAP_EN
  output logic                                               multi_hit_err_out,
`endif
  output logic [COUNTER_WIDTH-1:0]                           hit_count_out,
  output logic [COUNTER_WIDTH-1:0]                           miss_count_out
);

  localparam int unsigned W = SINGLE_ELEMENT_SIZE_IN_BITS;

  logic                       accept_c;
  logic                       sel_hit_c;
  logic                       sel_multi_c;
  logic [WAY_INDEX_WIDTH-1:0] sel_idx_c;
  logic [W-1:0]               sel_data_c;
  logic                       fwd_hit_c;
  logic [W-1:0]               fwd_data_c;

  // The stage accepts a request when it is empty or when it drains in the same cycle.
  assign ready_out = !valid_out || ready_in;
  assign accept_c  = valid_in && ready_out;

  // Priority select: the loop runs from way 0 upward, so the highest set bit is written last and wins.
  always_comb begin
    sel_idx_c  = '0;
    sel_data_c = '0;
    for (int g = 0; g < int'(NUMBER_WAYS); g++) begin
      if (sel_in[g]) begin
        sel_idx_c  = WAY_INDEX_WIDTH'(g);
        sel_data_c = way_packed_in[g*W +: W];
      end
    end
  end

  assign sel_hit_c = |sel_in;
  // x & (x-1) clears the lowest set bit, so any remaining bit means two or more hits.
  assign sel_multi_c = |(sel_in & (sel_in - NUMBER_WAYS'(1)));

`ifdef ASSOC_MULTI_HIT_TRAP_EN
  // Corrupt multi-hit data is never forwarded.
  assign fwd_hit_c  = sel_hit_c && !sel_multi_c;
  assign fwd_data_c = sel_multi_c ? '0 : sel_data_c;
`else
  assign fwd_hit_c  = sel_hit_c;
  assign fwd_data_c = sel_data_c;
`endif

  // Result registers and the valid bit.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      valid_out      <= 1'b0;
      way_packed_out <= '0;
      way_index_out  <= '0;
      hit_out        <= 1'b0;
      multi_hit_out  <= 1'b0;
    end else if (accept_c) begin
      valid_out      <= 1'b1;
      way_packed_out <= fwd_data_c;
      way_index_out  <= sel_idx_c;
      hit_out        <= fwd_hit_c;
      multi_hit_out  <= sel_multi_c;
    end else if (ready_in) begin
      valid_out      <= 1'b0;
    end
  end

  // Saturating statistics. A clear discards the increment from a concurrent accept.
  always_ff @(posedge clk_in) begin
    if (reset_in || clear_stats_in) begin
      hit_count_out  <= '0;
      miss_count_out <= '0;
    end else if (accept_c) begin
      if (sel_hit_c) begin
        if (hit_count_out != '1) hit_count_out <= hit_count_out + COUNTER_WIDTH'(1);
      end else begin
        if (miss_count_out != '1) miss_count_out <= miss_count_out + COUNTER_WIDTH'(1);
      end
    end
  end

`ifdef ASSOC_MULTI_HIT_TRAP_EN
  // Sticky multi-hit error flag. A clear wins over a concurrent set.
  always_ff @(posedge clk_in) begin
    if (reset_in || clear_stats_in) begin
      multi_hit_err_out <= 1'b0;
    end else if (accept_c && sel_multi_c) begin
      multi_hit_err_out <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_assoc_way_select_pipe.sv
// Directed self-checking bench for assoc_way_select_pipe (16 ways, 32-bit elements,
// 4-bit counters) plus a 1-way instance for the single-way boundary.
module tb_assoc_way_select_pipe;

  localparam int unsigned NW = 16;
  localparam int unsigned EW = 32;
  localparam int unsigned CW = 4;

  logic             clk_in = 1'b0;
  logic             reset_in;
  logic [EW*NW-1:0] way_packed_in;
  logic [NW-1:0]    sel_in;
  logic             valid_in;
  logic             ready_out;
  logic [EW-1:0]    way_packed_out;
  logic [3:0]       way_index_out;
  logic             hit_out;
  logic             multi_hit_out;
  logic             valid_out;
  logic             ready_in;
  logic             clear_stats_in;
  logic [CW-1:0]    hit_count_out;
  logic [CW-1:0]    miss_count_out;
`ifdef ASSOC_MULTI_HIT_TRAP_EN
  logic             multi_hit_err_out;
  logic             one_err;
`endif

  // Single-way instance
  logic [7:0]    one_way;
  logic          one_sel;
  logic          one_ready;
  logic [7:0]    one_data;
  logic [0:0]    one_idx;
  logic          one_hit;
  logic          one_multi;
  logic          one_valid;
  logic [CW-1:0] one_hits;
  logic [CW-1:0] one_misses;

  int n_checks = 0;
  int n_errors = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  always #5 clk_in = ~clk_in;

  assign one_way = 8'h5A;
  assign one_sel = sel_in[0];

  assoc_way_select_pipe #(
    .NUMBER_WAYS(NW), .SINGLE_ELEMENT_SIZE_IN_BITS(EW),
    .WAY_INDEX_WIDTH(4), .COUNTER_WIDTH(CW)
  ) u_dut (
    .clk_in(clk_in), .reset_in(reset_in), .way_packed_in(way_packed_in),
    .sel_in(sel_in), .valid_in(valid_in), .ready_out(ready_out),
    .way_packed_out(way_packed_out), .way_index_out(way_index_out),
    .hit_out(hit_out), .multi_hit_out(multi_hit_out), .valid_out(valid_out),
    .ready_in(ready_in), .clear_stats_in(clear_stats_in),
`ifdef ASSOC_MULTI_HIT_TRAP_EN
    .multi_hit_err_out(multi_hit_err_out),
`endif
    .hit_count_out(hit_count_out), .miss_count_out(miss_count_out)
  );

  assoc_way_select_pipe #(
    .NUMBER_WAYS(1), .SINGLE_ELEMENT_SIZE_IN_BITS(8),
    .WAY_INDEX_WIDTH(1), .COUNTER_WIDTH(CW)
  ) u_one (
    .clk_in(clk_in), .reset_in(reset_in), .way_packed_in(one_way),
    .sel_in(one_sel), .valid_in(valid_in), .ready_out(one_ready),
    .way_packed_out(one_data), .way_index_out(one_idx),
    .hit_out(one_hit), .multi_hit_out(one_multi), .valid_out(one_valid),
    .ready_in(ready_in), .clear_stats_in(clear_stats_in),
`ifdef ASSOC_MULTI_HIT_TRAP_EN
    .multi_hit_err_out(one_err),
`endif
    .hit_count_out(one_hits), .miss_count_out(one_misses)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Update the bench's saturating counter model for one accepted request.
  task automatic count(input logic hit);
    if (hit) exp_hits = (exp_hits < 15) ? exp_hits + 1 : 15;
    else     exp_miss = (exp_miss < 15) ? exp_miss + 1 : 15;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_hits"}, 64'(hit_count_out), 64'(exp_hits));
    check({tag, "_miss"}, 64'(miss_count_out), 64'(exp_miss));
  endtask

  initial begin
    for (int g = 0; g < int'(NW); g++) way_packed_in[g*EW +: EW] = 32'hA000_0000 + 32'(g);
    reset_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1; clear_stats_in = 1'b0; sel_in = '0;
    tick(); tick();
    reset_in = 1'b0;
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_data", 64'(way_packed_out), 64'd0);
    check("rst_ready", 64'(ready_out), 64'd1);
    check_counts("rst");

    // Single hit on way 4
    valid_in = 1'b1; sel_in = 16'h0010;
    tick(); count(1'b1);
    check("h4_valid", 64'(valid_out), 64'd1);
    check("h4_data", 64'(way_packed_out), 64'hA000_0004);
    check("h4_idx", 64'(way_index_out), 64'd4);
    check("h4_hit", 64'(hit_out), 64'd1);
    check("h4_multi", 64'(multi_hit_out), 64'd0);
    check_counts("h4");
    check("one_miss_hit", 64'(one_hit), 64'd0);

    // Multi-hit on ways 0 and 15
    sel_in = 16'h8001;
    tick(); count(1'b1);
    check("mh_idx", 64'(way_index_out), 64'd15);
    check("mh_multi", 64'(multi_hit_out), 64'd1);
`ifdef ASSOC_MULTI_HIT_TRAP_EN
    check("mh_data", 64'(way_packed_out), 64'd0);
    check("mh_hit", 64'(hit_out), 64'd0);
    check("mh_err", 64'(multi_hit_err_out), 64'd1);
`else
    check("mh_data", 64'(way_packed_out), 64'hA000_000F);
    check("mh_hit", 64'(hit_out), 64'd1);
`endif
    check_counts("mh");
    check("one_data", 64'(one_data), 64'h5A);
    check("one_idx", 64'(one_idx), 64'd0);
    check("one_multi", 64'(one_multi), 64'd0);
    check("one_hit", 64'(one_hit), 64'd1);

    // Miss
    sel_in = 16'h0000;
    tick(); count(1'b0);
    check("ms_hit", 64'(hit_out), 64'd0);
    check("ms_data", 64'(way_packed_out), 64'd0);
    check("ms_idx", 64'(way_index_out), 64'd0);
    check("ms_valid", 64'(valid_out), 64'd1);
    check_counts("ms");

    // Load a result on way 1, then hold it under backpressure
    sel_in = 16'h0002;
    tick(); count(1'b1);
    check("bp0_data", 64'(way_packed_out), 64'hA000_0001);
    ready_in = 1'b0; sel_in = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", 64'(ready_out), 64'd0);
      tick();
      check("bp_valid", 64'(valid_out), 64'd1);
      check("bp_data", 64'(way_packed_out), 64'hA000_0001);
      check("bp_idx", 64'(way_index_out), 64'd1);
      check_counts("bp");
    end
`ifdef ASSOC_MULTI_HIT_TRAP_EN
    check("err_sticky", 64'(multi_hit_err_out), 64'd1);
`endif

    // Release: back-to-back results without a bubble
    ready_in = 1'b1;
    #1 check("rel_ready", 64'(ready_out), 64'd1);
    tick(); count(1'b1);
    check("b2b0_valid", 64'(valid_out), 64'd1);
    check("b2b0_idx", 64'(way_index_out), 64'd8);
    sel_in = 16'h0200;
    tick(); count(1'b1);
    check("b2b1_valid", 64'(valid_out), 64'd1);
    check("b2b1_data", 64'(way_packed_out), 64'hA000_0009);
    check_counts("b2b");

    // Drain with no new request: valid drops and the data holds
    valid_in = 1'b0;
    tick();
    check("drain_valid", 64'(valid_out), 64'd0);
    check("drain_data", 64'(way_packed_out), 64'hA000_0009);

    // Saturation: 20 hits into a 4-bit counter
    valid_in = 1'b1; sel_in = 16'h0004;
    for (int i = 0; i < 20; i++) begin
      tick(); count(1'b1);
    end
    check("sat_hits", 64'(hit_count_out), 64'd15);
    check_counts("sat");

    // Clear together with a valid hit: the clear wins and the result still loads
    clear_stats_in = 1'b1; sel_in = 16'h0008;
    tick();
    clear_stats_in = 1'b0; exp_hits = 0; exp_miss = 0;
    check_counts("clr");
    check("clr_data", 64'(way_packed_out), 64'hA000_0003);
`ifdef ASSOC_MULTI_HIT_TRAP_EN
    check("clr_err", 64'(multi_hit_err_out), 64'd0);
`endif

    // Reset mid-stream while valid_out is 1
    ready_in = 1'b0; sel_in = 16'h8000; reset_in = 1'b1;
    tick();
    reset_in = 1'b0; valid_in = 1'b0;
    check("mrst_valid", 64'(valid_out), 64'd0);
    check("mrst_data", 64'(way_packed_out), 64'd0);
    check("mrst_idx", 64'(way_index_out), 64'd0);
    check("mrst_hit", 64'(hit_out), 64'd0);
    check("mrst_multi", 64'(multi_hit_out), 64'd0);
    check("mrst_ready", 64'(ready_out), 64'd1);
    check_counts("mrst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
